// File: rtl/gptp_tx_frame_buf_if.sv
// gptp_tx_frame_buf_if: bundles the gptp engine word write / read-back port,
// the MAC TX byte stream and the drop strobe of gptp_tx_frame_buf.
// The RTC inputs and TX timestamp outputs exist only when GPTP_TX_TS_EN is defined.
// master = engine/MAC side (drives writes, reads, mac_tx_ready); slave = buffer.
interface gptp_tx_frame_buf_if #(
    parameter int DATA_W = 80,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] gptp_wr_addr;
    logic [DATA_W-1:0] gptp_wr_data;
    logic              gptp_wr_vaild;
    logic              gptp_wr_vaild_ready;
    logic              gptp_wr_ready;
    logic [ADDR_W-1:0] gptp_rd_addr;
    logic [DATA_W-1:0] gptp_rd_data;
    logic [7:0]        mac_tx_data;
    logic              mac_tx_valid;
    logic              mac_tx_sof;
    logic              mac_tx_eof;
    logic              mac_tx_ready;
    logic              err_drop;
`ifdef GPTP_TX_TS_EN
    logic [31:0]       rtc_nanosec_field;
    logic [31:0]       rtc_sec_field;
    logic [15:0]       rtc_epoch_field;
    logic [31:0]       tx_ts_nanosec;
    logic [31:0]       tx_ts_sec;
    logic [15:0]       tx_ts_epoch;
    logic              tx_ts_vaild;

    modport master (
        output gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr, mac_tx_ready,
               rtc_nanosec_field, rtc_sec_field, rtc_epoch_field,
        input  gptp_wr_vaild_ready, gptp_wr_ready, gptp_rd_data,
               mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof, err_drop,
               tx_ts_nanosec, tx_ts_sec, tx_ts_epoch, tx_ts_vaild
    );
    modport slave (
        input  gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr, mac_tx_ready,
               rtc_nanosec_field, rtc_sec_field, rtc_epoch_field,
        output gptp_wr_vaild_ready, gptp_wr_ready, gptp_rd_data,
               mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof, err_drop,
               tx_ts_nanosec, tx_ts_sec, tx_ts_epoch, tx_ts_vaild
    );
`else
    modport master (
        output gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr, mac_tx_ready,
        input  gptp_wr_vaild_ready, gptp_wr_ready, gptp_rd_data,
               mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof, err_drop
    );
    modport slave (
        input  gptp_wr_addr, gptp_wr_data, gptp_wr_vaild, gptp_rd_addr, mac_tx_ready,
        output gptp_wr_vaild_ready, gptp_wr_ready, gptp_rd_data,
               mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof, err_drop
    );
`endif
endinterface

// File: rtl/gptp_tx_frame_buf.sv
// gptp_tx_frame_buf: captures the gptp engine's frame words, serialises them
// MSB byte first onto the MAC TX byte stream and pulses gptp_wr_ready once the
// eof byte has been accepted. The same word buffer serves engine read-back.
// Optional feature macro: GPTP_TX_TS_EN adds the SOF TX timestamp capture.
module gptp_tx_frame_buf #(
    parameter int DATA_W = 80,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    gptp_tx_frame_buf_if.slave bus
);
    localparam int BPW    = DATA_W / 8;
    localparam int WORD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BPW - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] last_q, last_d;   // highest word index of the frame
    logic              have_q, have_d;   // frame holds at least one in-range word
    logic [WORD_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range, rd_in_range, wr_en;
    logic [WORD_W-1:0] wr_idx, rd_idx;
    logic [DATA_W-1:0] cur_shifted;
    logic [7:0]        cur_byte;
    logic              vaild_ready, wr_ready, tx_valid, tx_sof, tx_eof;
    logic [7:0]        tx_data;

    assign wr_in_range = int'(bus.gptp_wr_addr) < DEPTH;
    assign rd_in_range = int'(bus.gptp_rd_addr) < DEPTH;
    assign wr_idx      = bus.gptp_wr_addr[WORD_W-1:0];
    assign rd_idx      = bus.gptp_rd_addr[WORD_W-1:0];
    assign wr_en       = bus.gptp_wr_vaild && wr_in_range &&
                         (state_q == S_IDLE || state_q == S_FILL);

    // Byte b of the current word sits at bits [DATA_W-1-8b -: 8]; shift it to the top.
    assign cur_shifted = mem[word_q] << {byte_q, 3'b000};
    assign cur_byte    = cur_shifted[DATA_W-1 -: 8];

    // Word buffer write port.
    // NOTE: the buffer has no reset so it maps onto plain RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= bus.gptp_wr_data;
    end

    // Registered read-back; reads the pre-write contents when addresses collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           rd_data_q <= '0;
        else if (rd_in_range) rd_data_q <= mem[rd_idx];
        else                  rd_data_q <= '0;
    end

    // Control state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            have_q  <= 1'b0;
            word_q  <= '0;
            byte_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            have_q  <= have_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode for fill / send / done sequencing.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        have_d      = have_q;
        word_d      = word_q;
        byte_d      = byte_q;
        err_d       = 1'b0;
        vaild_ready = 1'b0;
        wr_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_sof      = 1'b0;
        tx_eof      = 1'b0;
        tx_data     = '0;
        case (state_q)
            S_IDLE: begin
                vaild_ready = 1'b1;
                if (bus.gptp_wr_vaild) begin
                    err_d   = !wr_in_range;
                    have_d  = wr_in_range;
                    if (wr_in_range) last_d = wr_idx;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                vaild_ready = 1'b1;
                if (bus.gptp_wr_vaild) begin
                    err_d = !wr_in_range;
                    if (wr_in_range) begin
                        have_d = 1'b1;
                        last_d = wr_idx;
                    end
                end else begin
                    word_d  = '0;
                    byte_d  = '0;
                    state_d = have_q ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                err_d    = bus.gptp_wr_vaild;
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                tx_sof   = (word_q == '0) && (byte_q == '0);
                tx_eof   = (word_q == last_q) && (byte_q == BYTE_LAST);
                if (bus.mac_tx_ready) begin
                    if (tx_eof) begin
                        state_d = S_DONE;
                    end else if (byte_q == BYTE_LAST) begin
                        byte_d = '0;
                        word_d = word_q + 1'b1;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                err_d    = bus.gptp_wr_vaild;
                wr_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.gptp_wr_vaild_ready = vaild_ready;
    assign bus.gptp_wr_ready       = wr_ready;
    assign bus.gptp_rd_data        = rd_data_q;
    assign bus.mac_tx_data         = tx_data;
    assign bus.mac_tx_valid        = tx_valid;
    assign bus.mac_tx_sof          = tx_sof;
    assign bus.mac_tx_eof          = tx_eof;
    assign bus.err_drop            = err_q;

`ifdef GPTP_TX_TS_EN
    logic [31:0] ts_ns_q, ts_sec_q;
    logic [15:0] ts_epoch_q;
    logic        ts_vld_q;
    logic        sof_accept;

    assign sof_accept = tx_valid && tx_sof && bus.mac_tx_ready;

    // Latch the live RTC as the sof byte is accepted; flag the update one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_ns_q    <= '0;
            ts_sec_q   <= '0;
            ts_epoch_q <= '0;
            ts_vld_q   <= 1'b0;
        end else begin
            ts_vld_q <= sof_accept;
            if (sof_accept) begin
                ts_ns_q    <= bus.rtc_nanosec_field;
                ts_sec_q   <= bus.rtc_sec_field;
                ts_epoch_q <= bus.rtc_epoch_field;
            end
        end
    end

    assign bus.tx_ts_nanosec = ts_ns_q;
    assign bus.tx_ts_sec     = ts_sec_q;
    assign bus.tx_ts_epoch   = ts_epoch_q;
    assign bus.tx_ts_vaild   = ts_vld_q;
`endif
endmodule

// File: tb/tb_gptp_tx_frame_buf.sv
// tb_gptp_tx_frame_buf: table-driven frame vectors plus hand-written sequences
// for out-of-range writes, writes during SEND, read-back, empty frames and
// mid-frame reset. A word-level model of the buffer supplies expected bytes.
module tb_gptp_tx_frame_buf;
    localparam int DATA_W = 80;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int BPW    = DATA_W / 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gptp_tx_frame_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gptp_tx_frame_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                nwords;
        bit                stall;
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] step;
        int                exp_bytes;
        int                exp_cycles;
    } frame_vec_t;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        logic [3:0]        wi;
        logic [DATA_W-1:0] w;
        wi = 4'(idx / BPW);
        w  = model_mem[wi] << (8 * (idx % BPW));
        return w[DATA_W-1 -: 8];
    endfunction

    // Call at posedge+1; returns at posedge+1 after the write edge.
    task automatic write_word(input int addr, input logic [DATA_W-1:0] data, input bit exp_err);
        bus.gptp_wr_vaild = 1'b1;
        bus.gptp_wr_addr  = 8'(addr);
        bus.gptp_wr_data  = data;
        @(posedge clk); #1;
        if (addr < DEPTH) model_mem[4'(addr)] = data;
        check($sformatf("err_drop wr addr %0d", addr), bus.err_drop, exp_err);
    endtask

    task automatic commit();
        bus.gptp_wr_vaild = 1'b0;
    endtask

    task automatic read_check(input int addr, input logic [DATA_W-1:0] exp);
        bus.gptp_rd_addr = 8'(addr);
        @(posedge clk); #1;
        check($sformatf("rd_data addr %0d", addr), bus.gptp_rd_data, exp);
    endtask

    // Collects one frame after commit(); optional write strobe during SEND at cycle inj.
    task automatic drain(input string tag, input bit stall, input int exp_bytes,
                         input int exp_cycles, input int inj);
        int idx    = 0;
        int cycles = 0;
        bit done   = 1'b0;
        int sof_i  = -10;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            bus.mac_tx_ready  = stall ? (i % 2 == 1) : 1'b1;
            bus.gptp_wr_vaild = (inj >= 0) && (i == inj);
            bus.gptp_wr_addr  = 8'd1;
            bus.gptp_wr_data  = '1;
`ifdef GPTP_TX_TS_EN
            bus.rtc_sec_field     = 32'(i + 1);
            bus.rtc_nanosec_field = 32'(5 + 100 * i);
            bus.rtc_epoch_field   = 16'(i);
`endif
            @(negedge clk);
            if (inj >= 0 && i == inj + 1) check({tag, " err_drop on"}, bus.err_drop, 1'b1);
            if (inj >= 0 && i == inj + 2) check({tag, " err_drop off"}, bus.err_drop, 1'b0);
`ifdef GPTP_TX_TS_EN
            if (i == sof_i + 1) begin
                check({tag, " ts_vaild"}, bus.tx_ts_vaild, 1'b1);
                check({tag, " ts_sec"}, bus.tx_ts_sec, 32'(sof_i + 1));
                check({tag, " ts_ns"}, bus.tx_ts_nanosec, 32'(5 + 100 * sof_i));
                check({tag, " ts_epoch"}, bus.tx_ts_epoch, 16'(sof_i));
            end
            if (i == sof_i + 2) check({tag, " ts_vaild off"}, bus.tx_ts_vaild, 1'b0);
`endif
            if (bus.mac_tx_valid) begin
                cycles++;
                check($sformatf("%s data byte %0d", tag, idx), bus.mac_tx_data, exp_byte(idx));
                if (bus.mac_tx_ready) begin
                    check($sformatf("%s sof byte %0d", tag, idx), bus.mac_tx_sof, idx == 0);
                    check($sformatf("%s eof byte %0d", tag, idx), bus.mac_tx_eof,
                          idx == exp_bytes - 1);
                    if (idx == 0) sof_i = i;
                    if (bus.mac_tx_eof) done = 1'b1;
                    idx++;
                end
            end
        end
        bus.gptp_wr_vaild = 1'b0;
        check({tag, " eof seen within budget"}, done, 1'b1);
        check({tag, " byte count"}, idx, exp_bytes);
        check({tag, " send cycles"}, cycles, exp_cycles);
        @(negedge clk);
        check({tag, " done wr_ready"}, bus.gptp_wr_ready, 1'b1);
        check({tag, " done mac_tx_valid"}, bus.mac_tx_valid, 1'b0);
        check({tag, " done vaild_ready"}, bus.gptp_wr_vaild_ready, 1'b0);
        @(negedge clk);
        check({tag, " idle wr_ready"}, bus.gptp_wr_ready, 1'b0);
        check({tag, " idle vaild_ready"}, bus.gptp_wr_vaild_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t        vecs [5];
        logic [DATA_W-1:0] old_w;
        int                idx;
        bit                hit;

        vecs[0] = '{4,  1'b0, 80'h0102030405060708090a, 80'h0, 40, 40};
        vecs[1] = '{4,  1'b1, 80'h0102030405060708090a, 80'h0, 40, 80};
        vecs[2] = '{1,  1'b0, 80'hffeeddccbbaa99887766, 80'h0, 10, 10};
        vecs[3] = '{16, 1'b0, 80'h00112233445566778899, 80'h01010101010101010101, 160, 160};
        vecs[4] = '{2,  1'b1, 80'h80000000000000000001, 80'h1, 20, 40};

        bus.gptp_wr_addr  = '0;
        bus.gptp_wr_data  = '0;
        bus.gptp_wr_vaild = 1'b0;
        bus.gptp_rd_addr  = '0;
        bus.mac_tx_ready  = 1'b0;
`ifdef GPTP_TX_TS_EN
        bus.rtc_sec_field     = '0;
        bus.rtc_nanosec_field = '0;
        bus.rtc_epoch_field   = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset vaild_ready", bus.gptp_wr_vaild_ready, 1'b1);
        check("reset wr_ready", bus.gptp_wr_ready, 1'b0);
        check("reset rd_data", bus.gptp_rd_data, '0);
        check("reset mac_tx_valid", bus.mac_tx_valid, 1'b0);
        check("reset mac_tx_sof", bus.mac_tx_sof, 1'b0);
        check("reset mac_tx_eof", bus.mac_tx_eof, 1'b0);
        check("reset mac_tx_data", bus.mac_tx_data, 8'h00);
        check("reset err_drop", bus.err_drop, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].nwords; k++)
                write_word(k, vecs[v].base + DATA_W'(k) * vecs[v].step, 1'b0);
            commit();
            drain($sformatf("vec%0d", v), vecs[v].stall, vecs[v].exp_bytes,
                  vecs[v].exp_cycles, -1);
        end

        // Out-of-range write in FILL, then a write strobe during SEND.
        for (int k = 0; k < 4; k++) write_word(k, 80'h11223344556677889900 + DATA_W'(k), 1'b0);
        write_word(20, 80'hdeadbeef, 1'b1);
        commit();
        drain("oor", 1'b0, 40, 40, 5);

        // Read-back of a freshly written word and of an out-of-range address.
        write_word(5, 80'habababaa, 1'b0);
        commit();
        drain("wr5", 1'b0, 60, 60, -1);
        read_check(5, 80'habababaa);
        read_check(17, '0);

        // Same-cycle write and read of one address returns the old word.
        old_w = model_mem[2];
        bus.gptp_rd_addr = 8'd2;
        write_word(2, 80'h5a5a5a5a5a5a5a5a5a5a, 1'b0);
        check("rd during wr old data", bus.gptp_rd_data, old_w);
        commit();
        drain("rdwr", 1'b0, 30, 30, -1);
        read_check(2, 80'h5a5a5a5a5a5a5a5a5a5a);

        // Only out-of-range writes: empty frame goes straight to DONE.
        write_word(20, 80'h1, 1'b1);
        commit();
        @(posedge clk); #1;
        check("empty wr_ready", bus.gptp_wr_ready, 1'b1);
        check("empty mac_tx_valid", bus.mac_tx_valid, 1'b0);
        @(posedge clk); #1;
        check("empty idle wr_ready", bus.gptp_wr_ready, 1'b0);
        check("empty idle vaild_ready", bus.gptp_wr_vaild_ready, 1'b1);

        // Reset asserted while byte 13 of a 3-word frame is presented.
        for (int k = 0; k < 3; k++) write_word(k, 80'hc0c1c2c3c4c5c6c7c8c9 + DATA_W'(k << 4), 1'b0);
        commit();
        idx = 0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            bus.mac_tx_ready = 1'b1;
            @(negedge clk);
            if (bus.mac_tx_valid) begin
                if (idx == 13) hit = 1'b1;
                else idx++;
            end
        end
        check("abort reached byte 13", hit, 1'b1);
        reset = 1'b0;
        #1;
        check("abort mac_tx_valid", bus.mac_tx_valid, 1'b0);
        check("abort vaild_ready", bus.gptp_wr_vaild_ready, 1'b1);
        check("abort wr_ready", bus.gptp_wr_ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("abort held wr_ready", bus.gptp_wr_ready, 1'b0);
            check("abort held mac_tx_valid", bus.mac_tx_valid, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("post abort vaild_ready", bus.gptp_wr_vaild_ready, 1'b1);
        for (int k = 0; k < 2; k++) write_word(k, 80'h0f0e0d0c0b0a09080706 + DATA_W'(k), 1'b0);
        commit();
        drain("post abort", 1'b0, 20, 20, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
